// File: rtl/regfile_spill_ctrl_pkg.sv
// Shared constants for the register-bank context save/restore engine:
// bank function codes, command encoding, register indices and enable idle value.
package regfile_spill_ctrl_pkg;

  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLEAR = 3'b011;
  localparam logic [2:0] FS_INC   = 3'b100;
  localparam logic [2:0] FS_DEC   = 3'b101;

  typedef enum logic {
    OP_SAVE    = 1'b0,
    OP_RESTORE = 1'b1
  } op_e;

  localparam logic [2:0] IDX_R1 = 3'd0;
  localparam logic [2:0] IDX_R2 = 3'd1;
  localparam logic [2:0] IDX_R3 = 3'd2;
  localparam logic [2:0] IDX_R4 = 3'd3;
  localparam logic [2:0] IDX_S1 = 3'd4;
  localparam logic [2:0] IDX_S2 = 3'd5;
  localparam logic [2:0] IDX_S3 = 3'd6;
  localparam logic [2:0] IDX_S4 = 3'd7;

  localparam logic [3:0] NO_ENABLE = 4'b1111;

endpackage

// File: rtl/regfile_spill_ctrl_enable_decode.sv
// Maps a bank index plus write flag onto the active-low RegSel/ScrSel pair.
// Bit 3 of each group addresses R1/S1, bit 0 addresses R4/S4.
module regfile_enable_decode
  import regfile_spill_ctrl_pkg::*;
(
  input  logic [2:0] i_idx,
  input  logic       i_wr,
  output logic [3:0] o_reg_sel,
  output logic [3:0] o_scr_sel
);

  always_comb begin
    o_reg_sel = NO_ENABLE;
    o_scr_sel = NO_ENABLE;
    if (i_wr) begin
      // ~idx[1:0] == 3 - idx[1:0], turning the index into the MSB-first bit position
      if (!i_idx[2]) o_reg_sel[~i_idx[1:0]] = 1'b0;
      else           o_scr_sel[~i_idx[1:0]] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_spill_ctrl.sv
// Context save/restore engine: walks the selected registers lowest index first,
// writing each to Base+k (SAVE) or loading it from Base+k (RESTORE).
module regfile_spill_ctrl
  import regfile_spill_ctrl_pkg::*;
#(
  parameter logic [2:0] FUNSEL_LOAD = FS_LOAD
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [7:0]  i_mask,
  input  logic [15:0] i_base,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_out_a_sel,
  input  logic [15:0] i_reg_out_a,
  output logic [15:0] o_i,
  output logic [2:0]  o_fun_sel,
  output logic [3:0]  o_reg_sel,
  output logic [3:0]  o_scr_sel,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_wr_valid,
  input  logic        i_mem_wr_ready,
  output logic        o_mem_rd_valid,
  input  logic        i_mem_rd_ready,
  input  logic        i_mem_rsp_valid,
  input  logic [15:0] i_mem_rsp_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SAVE_WR = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_LOAD    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]  r_state;
  logic [7:0]  r_mask;
  logic [15:0] r_base;
  logic [15:0] r_hold;

  logic [2:0]  w_idx;
  logic [7:0]  w_mask_clr;
  logic [15:0] w_addr;
  logic        w_load;
  logic        w_save;
  logic        w_rd_req;

  // Lowest set bit wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_idx = 3'(i);
    end
  end

  assign w_mask_clr = r_mask & ~(8'd1 << w_idx);
  assign w_addr     = r_base + {13'd0, w_idx};
  assign w_load     = (r_state == S_LOAD);
  assign w_save     = (r_state == S_SAVE_WR);
  assign w_rd_req   = (r_state == S_RD_REQ);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mask  <= 8'd0;
      r_base  <= 16'd0;
      r_hold  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mask <= i_mask;
            r_base <= i_base;
            if (i_mask == 8'd0)                  r_state <= S_FIN;
            else if (op_e'(i_op) == OP_RESTORE) r_state <= S_RD_REQ;
            else                                 r_state <= S_SAVE_WR;
          end
        end
        S_SAVE_WR: begin
          if (i_mem_wr_ready) begin
            r_mask <= w_mask_clr;
            if (w_mask_clr == 8'd0) r_state <= S_FIN;
          end
        end
        S_RD_REQ: begin
          if (i_mem_rd_ready) r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (i_mem_rsp_valid) begin
            r_hold  <= i_mem_rsp_data;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_mask  <= w_mask_clr;
          r_state <= (w_mask_clr == 8'd0) ? S_FIN : S_RD_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // All outputs decode from registered state, so a reset lands them at idle values at once.
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = (r_state == S_FIN);
  assign o_mem_wr_valid = w_save;
  assign o_mem_rd_valid = w_rd_req;
  assign o_out_a_sel    = w_save ? w_idx : 3'd0;
  assign o_mem_addr     = (w_save || w_rd_req) ? w_addr : 16'd0;
  assign o_mem_wdata    = w_save ? i_reg_out_a : 16'd0;
  assign o_i            = w_load ? r_hold : 16'd0;
  assign o_fun_sel      = FUNSEL_LOAD;

  regfile_enable_decode u_enable_decode (
    .i_idx     (w_idx),
    .i_wr      (w_load),
    .o_reg_sel (o_reg_sel),
    .o_scr_sel (o_scr_sel)
  );

endmodule

// File: tb/tb_regfile_spill_ctrl.sv
// Bench for regfile_spill_ctrl: behavioural bank + memory model, directed scenarios
// and randomized save/restore commands checked against a list-level reference.
module tb_regfile_spill_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  mask = 8'd0;
  logic [15:0] base = 16'd0;
  logic        busy, done;
  logic [2:0]  out_a_sel, fun_sel;
  logic [15:0] reg_out_a, i_data, mem_addr, mem_wdata;
  logic [3:0]  reg_sel, scr_sel;
  logic        mem_wr_valid, mem_rd_valid;
  logic        mem_wr_ready = 1'b1, mem_rd_ready = 1'b1, mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'd0;

  logic [15:0] bank [8];
  logic [15:0] mem [65536];
  logic [31:0] wlog [$];
  logic [7:0]  elog [$];
  int          rd_count = 0;
  int          checks = 0;
  int          failures = 0;

  int          wr_low_cnt = 0;
  bit          rand_ready = 1'b0;
  int          rsp_delay = 1;

  localparam logic [65:0] RESET_OUTS = {4'b0000, 4'hF, 4'hF, 3'd0, 16'd0, 16'd0, 16'd0, 3'b010};

  always #5 clk = ~clk;

  assign reg_out_a = bank[out_a_sel];

  regfile_spill_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_mask(mask), .i_base(base),
    .o_busy(busy), .o_done(done), .o_out_a_sel(out_a_sel), .i_reg_out_a(reg_out_a),
    .o_i(i_data), .o_fun_sel(fun_sel), .o_reg_sel(reg_sel), .o_scr_sel(scr_sel),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wr_valid(mem_wr_valid), .i_mem_wr_ready(mem_wr_ready),
    .o_mem_rd_valid(mem_rd_valid), .i_mem_rd_ready(mem_rd_ready),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_data(mem_rsp_data)
  );

  // Memory + bank model: drive inputs at negedge, observe handshakes 1 time unit later.
  initial begin
    bit          rsp_pend = 1'b0;
    int          rsp_cnt = 0;
    logic [15:0] rsp_addr = 16'd0;
    bit          wr_wait = 1'b0, rd_wait = 1'b0;
    logic [15:0] wr_addr_p = 16'd0, wr_data_p = 16'd0, rd_addr_p = 16'd0;
    forever begin
      @(negedge clk);
      if (wr_low_cnt > 0) begin
        mem_wr_ready = 1'b0;
        wr_low_cnt--;
      end else begin
        mem_wr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      mem_rd_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 16'($urandom);
      if (rsp_pend) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem[rsp_addr];
          rsp_pend      = 1'b0;
        end
      end else if (rand_ready && ($urandom_range(0, 3) == 0)) begin
        mem_rsp_valid = 1'b1;
      end
      #1;
      if (rst) begin
        wr_wait = 1'b0;
        rd_wait = 1'b0;
      end else begin
        if (wr_wait) begin
          checks++;
          if (!mem_wr_valid || mem_addr !== wr_addr_p || mem_wdata !== wr_data_p) begin
            failures++;
            $display("FAIL wr_stable: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                     mem_wr_valid, mem_addr, mem_wdata, wr_addr_p, wr_data_p);
          end
        end
        if (rd_wait) begin
          checks++;
          if (!mem_rd_valid || mem_addr !== rd_addr_p) begin
            failures++;
            $display("FAIL rd_stable: got v=%b a=%h want v=1 a=%h", mem_rd_valid, mem_addr, rd_addr_p);
          end
        end
        wr_wait = mem_wr_valid && !mem_wr_ready;
        wr_addr_p = mem_addr;
        wr_data_p = mem_wdata;
        rd_wait = mem_rd_valid && !mem_rd_ready;
        rd_addr_p = mem_addr;
        if (mem_wr_valid && mem_wr_ready) begin
          mem[mem_addr] = mem_wdata;
          wlog.push_back({mem_addr, mem_wdata});
        end
        if (mem_rd_valid && mem_rd_ready) begin
          if (rsp_pend) begin
            failures++;
            $display("FAIL rd_outstanding: got 2 requests want at most 1");
          end
          rsp_pend = 1'b1;
          rsp_cnt  = rsp_delay;
          rsp_addr = mem_addr;
          rd_count++;
        end
        if ({reg_sel, scr_sel} != 8'hFF) begin
          elog.push_back({reg_sel, scr_sel});
          if (fun_sel == 3'b010) begin
            for (int k = 0; k < 4; k++) begin
              if (!reg_sel[3-k]) bank[k]   = i_data;
              if (!scr_sel[3-k]) bank[k+4] = i_data;
            end
          end
        end
      end
    end
  end

  task automatic run_cmd(input logic op_v, input logic [7:0] mask_v, input logic [15:0] base_v,
                         output int cyc);
    wlog.delete();
    elog.delete();
    rd_count = 0;
    @(negedge clk);
    start = 1'b1; op = op_v; mask = mask_v; base = base_v;
    @(negedge clk);
    start = 1'b0; op = ~op_v; mask = 8'($urandom); base = 16'($urandom);
    cyc = 0;
    forever begin
      #2;
      cyc++;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_in_cmd: got %b want 1 at cycle %0d", busy, cyc);
      end
      if (done === 1'b1) break;
      if (cyc > 400) begin
        failures++;
        $display("FAIL cmd_timeout: got no done want done within 400 cycles");
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    #2;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_done: got busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({busy, done, mem_wr_valid, mem_rd_valid, reg_sel, scr_sel, out_a_sel, i_data, mem_addr,
         mem_wdata, fun_sel} !== RESET_OUTS) begin
      failures++;
      $display("FAIL reset_outputs: got %h want %h", {busy, done, mem_wr_valid, mem_rd_valid, reg_sel,
               scr_sel, out_a_sel, i_data, mem_addr, mem_wdata, fun_sel}, RESET_OUTS);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got busy,done=%b%b want 00", busy, done);
    end
  endtask

  task automatic test_save_basic();
    int cyc;
    bank[0] = 16'hAAAA;
    bank[7] = 16'h5555;
    run_cmd(1'b0, 8'h81, 16'h0100, cyc);
    checks++;
    if (cyc != 3) begin failures++; $display("FAIL save_done_cycle: got %0d want 3", cyc); end
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 32'h0100_AAAA || wlog[1] !== 32'h0107_5555) begin
      failures++;
      $display("FAIL save_writes: got n=%0d %p want 0100AAAA 01075555", wlog.size(), wlog);
    end
    checks++;
    if (elog.size() != 0) begin failures++; $display("FAIL save_no_enable: got %0d want 0", elog.size()); end
  endtask

  task automatic test_restore_basic();
    int cyc;
    mem[16'h0201] = 16'h1234;
    mem[16'h0204] = 16'hBEEF;
    run_cmd(1'b1, 8'h12, 16'h0200, cyc);
    checks++;
    if (cyc != 7) begin failures++; $display("FAIL restore_done_cycle: got %0d want 7", cyc); end
    checks++;
    if (elog.size() != 2 || elog[0] !== 8'hBF || elog[1] !== 8'hF7) begin
      failures++;
      $display("FAIL restore_enables: got n=%0d %p want BF F7", elog.size(), elog);
    end
    checks++;
    if (bank[1] !== 16'h1234 || bank[4] !== 16'hBEEF) begin
      failures++;
      $display("FAIL restore_values: got R2=%h S1=%h want 1234 BEEF", bank[1], bank[4]);
    end
  endtask

  task automatic test_write_stall();
    int cyc;
    bank[0] = 16'h0F0F;
    bank[2] = 16'hC3C3;
    wr_low_cnt = 6;
    run_cmd(1'b0, 8'h05, 16'h0400, cyc);
    checks++;
    if (cyc != 8) begin failures++; $display("FAIL stall_done_cycle: got %0d want 8", cyc); end
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 32'h0400_0F0F || wlog[1] !== 32'h0402_C3C3) begin
      failures++;
      $display("FAIL stall_writes: got n=%0d %p want 04000F0F 0402C3C3", wlog.size(), wlog);
    end
  endtask

  task automatic test_mask_zero_and_ignore();
    int cyc;
    run_cmd(1'b0, 8'h00, 16'h1234, cyc);
    checks++;
    if (cyc != 1 || wlog.size() != 0 || rd_count != 0) begin
      failures++;
      $display("FAIL mask_zero: got cyc=%0d wr=%0d rd=%0d want 1 0 0", cyc, wlog.size(), rd_count);
    end
    // SAVE of two registers with a restore-all Start held high while busy.
    wlog.delete();
    elog.delete();
    rd_count = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; mask = 8'h03; base = 16'h0300;
    @(negedge clk);
    op = 1'b1; mask = 8'hFF;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      #2;
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL ignore_start_busy: got %b want 0", busy); end
      @(negedge clk);
    end
    checks++;
    if (wlog.size() != 2 || rd_count != 0 || elog.size() != 0) begin
      failures++;
      $display("FAIL ignore_start: got wr=%0d rd=%0d en=%0d want 2 0 0", wlog.size(), rd_count, elog.size());
    end
  endtask

  task automatic test_reset_mid_restore();
    logic [15:0] keep;
    keep = bank[0];
    mem[16'h0500] = ~keep;
    rsp_delay = 4;
    elog.delete();
    @(negedge clk);
    start = 1'b1; op = 1'b1; mask = 8'h01; base = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if ({busy, done, mem_wr_valid, mem_rd_valid, reg_sel, scr_sel, out_a_sel, i_data, mem_addr,
         mem_wdata, fun_sel} !== RESET_OUTS) begin
      failures++;
      $display("FAIL midreset_outputs: got %h want %h", {busy, done, mem_wr_valid, mem_rd_valid, reg_sel,
               scr_sel, out_a_sel, i_data, mem_addr, mem_wdata, fun_sel}, RESET_OUTS);
    end
    repeat (6) begin
      @(negedge clk);
      #2;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet: got busy,done=%b%b want 00", busy, done);
      end
    end
    checks++;
    if (elog.size() != 0 || bank[0] !== keep) begin
      failures++;
      $display("FAIL midreset_bank: got en=%0d R1=%h want 0 %h", elog.size(), bank[0], keep);
    end
    rsp_delay = 1;
  endtask

  task automatic test_wrap();
    int cyc;
    bank[2] = 16'h2222;
    bank[3] = 16'h3333;
    run_cmd(1'b0, 8'h0C, 16'hFFFE, cyc);
    checks++;
    if (wlog.size() != 2 || wlog[0] !== 32'h0000_2222 || wlog[1] !== 32'h0001_3333) begin
      failures++;
      $display("FAIL wrap_writes: got n=%0d %p want 00002222 00013333", wlog.size(), wlog);
    end
  endtask

  task automatic test_random();
    int          cyc;
    logic        opv;
    logic [7:0]  m;
    logic [15:0] b;
    logic [31:0] exp_w [$];
    logic [7:0]  exp_e [$];
    logic [15:0] exp_bank [8];
    rand_ready = 1'b1;
    for (int t = 0; t < 24; t++) begin
      opv = 1'($urandom);
      m   = 8'($urandom);
      b   = 16'($urandom);
      rsp_delay = $urandom_range(1, 3);
      exp_w.delete();
      exp_e.delete();
      for (int k = 0; k < 8; k++) begin
        bank[k] = 16'($urandom);
        mem[b + 16'(k)] = 16'($urandom);
      end
      for (int k = 0; k < 8; k++) exp_bank[k] = bank[k];
      for (int k = 0; k < 8; k++) begin
        if (m[k]) begin
          if (!opv) begin
            exp_w.push_back({b + 16'(k), bank[k]});
          end else begin
            exp_bank[k] = mem[b + 16'(k)];
            exp_e.push_back((k < 4) ? {~(4'b1000 >> k), 4'hF} : {4'hF, ~(4'b1000 >> (k - 4))});
          end
        end
      end
      run_cmd(opv, m, b, cyc);
      checks++;
      if (wlog != exp_w) begin
        failures++;
        $display("FAIL rand_writes[%0d]: got %p want %p", t, wlog, exp_w);
      end
      checks++;
      if (elog != exp_e) begin
        failures++;
        $display("FAIL rand_enables[%0d]: got %p want %p", t, elog, exp_e);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (bank[k] !== exp_bank[k]) begin
          failures++;
          $display("FAIL rand_bank[%0d][%0d]: got %h want %h", t, k, bank[k], exp_bank[k]);
        end
      end
    end
    rand_ready = 1'b0;
    rsp_delay = 1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) bank[k] = 16'd0;
    test_reset();
    test_save_basic();
    test_restore_basic();
    test_write_stall();
    test_mask_zero_and_ignore();
    test_reset_mid_restore();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/regfile_spill_ctrl.md
# regfile_spill_ctrl

Context save/restore engine for the 8-entry register bank (R1–R4, S1–S4). It sits between the control unit and data memory. On command it either reads the selected registers through the A read port and writes them to memory (SAVE), or reads words from memory and loads them into the registers through the write port (RESTORE). It drives the bank's OutASel, I, FunSel, RegSel and ScrSel signals directly.

## Interface
- Parameters
  - FUNSEL_LOAD, 3'b010: FunSel code for parallel load.
- Ports
  - Clock  in  1  single clock, rising edge
  - Reset  in  1  synchronous, active-high
  - Start  in  1  command strobe, sampled only in IDLE
  - Op  in  1  0 = SAVE, 1 = RESTORE
  - Mask  in  8  bit k selects register k (0–3 = R1–R4, 4–7 = S1–S4); captured at Start
  - Base  in  16  memory base address; register k uses slot Base+k; captured at Start
  - Busy  out  1  high from the cycle after an accepted Start until Done
  - Done  out  1  one-cycle completion pulse
  - OutASel  out  3  bank read-port select (k)
  - RegOutA  in  16  bank read-port data (combinational from OutASel)
  - I  out  16  bank write data
  - FunSel  out  3  bank function select
  - RegSel, ScrSel  out  4 each  active-low enables; bit3 = R1/S1 … bit0 = R4/S4; 4'b1111 = none
  - MemAddr  out  16  address for write or read request
  - MemWData  out  16  write data
  - MemWrValid / MemWrReady  out / in  1  write handshake
  - MemRdValid / MemRdReady  out / in  1  read-request handshake
  - MemRspValid / MemRspData  in / in  1 / 16  read response, ≥1 cycle after request accept

## Operation
- States: IDLE, SAVE_WR, RD_REQ, RD_WAIT, LOAD, FIN.
- Working mask: the lowest set bit is the current index k. It is cleared when register k completes.
- IDLE, Start=1:
  - capture Mask and Base.
  - Mask=0 → FIN.
  - Op=0 → SAVE_WR.
  - Op=1 → RD_REQ.
- SAVE_WR: OutASel=k, MemWData=RegOutA, MemAddr=Base+k, MemWrValid=1. On MemWrReady, clear bit k; if the mask is now empty go to FIN, else stay in SAVE_WR with the next k.
- RD_REQ: MemAddr=Base+k, MemRdValid=1. On MemRdReady go to RD_WAIT.
- RD_WAIT: wait for MemRspValid, capture MemRspData into a 16-bit holding register, go to LOAD.
- LOAD (one cycle):
  - I = holding register, FunSel=FUNSEL_LOAD.
  - Drive only register k's enable bit low (RegSel for k<4, ScrSel for k≥4); all other enables stay 1.
  - Clear bit k; go to RD_REQ or FIN.
- FIN: Done=1 for one cycle, then IDLE.
- Ordering: at most one memory request outstanding. Valid, address and data are held stable until ready.
- Address arithmetic is modulo 2^16 (Base=16'hFFFF, k=1 → 16'h0000).
- Ignored inputs:
  - Start while not IDLE.
  - MemRspValid outside RD_WAIT.
  - MemRdReady/MemWrReady when the matching valid is low.
- Outside LOAD:
  - RegSel=ScrSel=4'b1111 and FunSel=FUNSEL_LOAD, so no bank write occurs.
  - I=0.
  - OutASel=k in SAVE_WR, else 0.

## Timing
- Reset values: state IDLE; Busy, Done, MemWrValid, MemRdValid = 0; RegSel=ScrSel=4'b1111; OutASel=0; I=0; MemAddr=0; MemWData=0; FunSel=FUNSEL_LOAD.
- Reset mid-operation: IDLE on the next edge, no Done, no further enables. A partially written bank is left as is.
- SAVE with ready tied high: N selected registers take N cycles in SAVE_WR, then Done in the following cycle.
- RESTORE with ready high and 1-cycle response: 3 cycles per register (RD_REQ, RD_WAIT, LOAD). The register updates at the LOAD clock edge.
- Start with Mask=0: Done exactly one cycle after Start, no memory traffic.
- Busy is high in every non-IDLE state, including FIN.

## Structure
- Shared package:
  - FunSel codes (LOAD, CLEAR, INC, DEC).
  - Op encoding.
  - Register index constants R1..S4 = 0..7.
  - NO_ENABLE = 4'b1111.
- Sub-module: regfile_enable_decode, mapping index k plus a write flag to the active-low {RegSel, ScrSel} pair.
- Lowest-set-bit selection is a plain priority encoder kept inline.

## Test plan
- SAVE, Mask=8'h81, Base=16'h0100, R1=16'hAAAA, S4=16'h5555, ready high → writes (0100, AAAA) then (0107, 5555), Done on cycle 3, no enable ever low.
- RESTORE, Mask=8'h12, Base=16'h0200, memory returns 1234 at 0201 and BEEF at 0204 → RegSel=4'b1011 for one cycle, then ScrSel=4'b0111 for one cycle; R2=1234, S1=BEEF.
- SAVE with MemWrReady low for 5 cycles → MemWrValid, MemAddr and MemWData stable throughout, exactly one write per register.
- Mask=0 → Done one cycle after Start; a second Start asserted while Busy is ignored.
- Reset asserted in RD_WAIT of a restore → all outputs at reset values next cycle, no Done, no bank write; a late MemRspValid is ignored.
- Base=16'hFFFE, Mask=8'h0C, SAVE → addresses 0000 and 0001.
